keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keypad. It drives the keypad rows one at a time and synchronizes and samples the columns. It debounces press and release, and turns each accepted key press into a single event. Each accepted press shifts into a two-digit history (`d0` newest, `d1` previous) that feeds the time-multiplexed dual seven-segment display path.

---
 rtl/keypad_scan_ctrl.sv | 99 +++++++++
 tb/tb_keypad_scan_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with press/release debounce and two-digit key history
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] d0,
    output logic [3:0] d1
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
    typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_RELEASE} state_t;
    state_t state;
    logic [3:0] c_meta, cs, col, code;
    logic [1:0] ri, nri, ci;
    logic [DW-1:0] dwell;
    logic [CW-1:0] cnt;
    logic hit;
    always_comb begin
        nri = ri + 2'd1;
        ci = {col[3] | col[2], col[3] | col[1]};
        code = KEYMAP[{ri, ci, 2'b00} +: 4];
        hit = |(cs & col);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SCAN;
            ri <= 2'd0;
            rows <= 4'b0001;
            dwell <= '0;
            cnt <= '0;
            col <= '0;
            c_meta <= '0;
            cs <= '0;
            key_code <= '0;
            d0 <= '0;
            d1 <= '0;
            key_valid <= 1'b0;
            key_held <= 1'b0;
        end else begin
            c_meta <= cols;
            cs <= c_meta;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DW'(SCAN_DIV - 1)) begin
                        dwell <= '0;
                        if ($onehot(cs)) begin
                            col <= cs;
                            cnt <= '0;
                            state <= DB_PRESS;
                        end else begin
                            ri <= nri;
                            rows <= 4'b0001 << nri;
                        end
                    end else dwell <= dwell + DW'(1);
                end
                DB_PRESS: begin
                    if (cs != col) begin
                        state <= SCAN;
                        ri <= nri;
                        rows <= 4'b0001 << nri;
                        dwell <= '0;
                    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        state <= HELD;
                        d1 <= d0;
                        d0 <= code;
                        key_code <= code;
                        key_valid <= 1'b1;
                        key_held <= 1'b1;
                    end else cnt <= cnt + CW'(1);
                end
                HELD: begin
                    if (!hit) begin
                        state <= DB_RELEASE;
                        cnt <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (hit) state <= HELD;
                    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        key_held <= 1'b0;
                        state <= SCAN;
                        ri <= nri;
                        rows <= 4'b0001 << nri;
                        dwell <= '0;
                    end else cnt <= cnt + CW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: randomized keypad scenarios checked against a key-history reference model
module tb_keypad_scan_ctrl;
    localparam int SD = 4;
    localparam int DB = 8;
    logic clk = 0, reset = 1;
    logic [3:0] cols, rows, key_code, d0, d1;
    logic key_valid, key_held;
    logic [15:0] keys = '0;
    int kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    int fk[4] = '{6, 11, 0, 13};
    int fm[4] = '{0, 0, 1, 3};
    int n_chk = 0, n_err = 0, n_ev = 0, ev_cyc = 0, cyc = 0, m_d0 = 0, m_d1 = 0, tgt = 0;
    logic rst_q = 0, kv_prev = 0;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .cols(cols), .rows(rows), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held), .d0(d0), .d1(d1)
    );

    always #5 clk = ~clk;

    // keypad: a closed key connects its row drive to its column; columns pulled low otherwise
    always_comb begin
        cols = '0;
        for (int c = 0; c < 4; c++)
            cols[c] = (rows[0] & keys[c]) | (rows[1] & keys[4+c]) | (rows[2] & keys[8+c]) | (rows[3] & keys[12+c]);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        rst_q = reset;
    end

    // reference model: two-deep history of accepted key codes
    initial forever begin
        @(negedge clk);
        if (rst_q) begin
            m_d0 = 0;
            m_d1 = 0;
            chk("rst_kv", int'(key_valid), 0);
            chk("rst_kh", int'(key_held), 0);
            chk("rst_rows", int'(rows), 1);
        end else if (key_valid) begin
            chk("ev_code", int'(key_code), kmap[tgt]);
            chk("ev_held", int'(key_held), 1);
            m_d1 = m_d0;
            m_d0 = kmap[tgt];
            n_ev++;
            ev_cyc = cyc;
        end
        chk("kv_pulse", int'(kv_prev & key_valid), 0);
        kv_prev = key_valid;
        chk("d0", int'(d0), m_d0);
        chk("d1", int'(d1), m_d1);
        chk("rows_onehot", int'($onehot(rows)), 1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    task automatic wait_ev(input int limit, input int n0);
        for (int i = 0; i < limit && n_ev == n0; i++) tick(1);
    endtask

    // close key while its row is idle, so it is seen at that row's next dwell sample
    task automatic press_timed(input int k);
        int r, n0, c0;
        r = k / 4;
        tgt = k;
        for (int i = 0; i < 40 && rows[r]; i++) tick(1);
        keys[k] = 1'b1;
        for (int i = 0; i < 40 && !rows[r]; i++) tick(1);
        c0 = cyc;
        n0 = n_ev;
        wait_ev(60, n0);
        chk("press_ev", n_ev - n0, 1);
        chk("press_lat", int'(ev_cyc - c0 >= SD + DB - 1 && ev_cyc - c0 <= SD + DB), 1);
        tick($urandom_range(5, 20));
        chk("held", int'(key_held), 1);
        chk("rows_frozen", int'(rows), 1 << r);
        chk("d0_key", int'(d0), kmap[k]);
    endtask

    task automatic release_chk(input int k);
        int r, c0;
        r = k / 4;
        keys[k] = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 40 && key_held; i++) tick(1);
        chk("rel_time", int'(cyc - c0 >= DB && cyc - c0 <= DB + 3), 1);
        chk("rel_rows", int'(rows), 1 << ((r + 1) % 4));
        tick(2);
    endtask

    initial begin
        int k, k2, mode, n0, r;
        do_reset(3);
        chk("init_d0", int'(d0), 0);
        chk("init_d1", int'(d1), 0);
        chk("init_kh", int'(key_held), 0);
        for (int i = 0; i < 16; i++) begin
            chk("scan_rows", int'(rows), 1 << ((i / 4) % 4));
            tick(1);
        end
        for (int it = 0; it < 16; it++) begin
            k = (it < 4) ? fk[it] : int'($urandom_range(0, 15));
            mode = (it < 4) ? fm[it] : int'($urandom_range(0, 4));
            r = k / 4;
            n0 = n_ev;
            case (mode)
                0: begin
                    press_timed(k);
                    release_chk(k);
                end
                1: begin
                    repeat ($urandom_range(2, 3)) begin
                        keys[k] = 1'b1;
                        tick($urandom_range(1, 5));
                        keys[k] = 1'b0;
                        tick($urandom_range(1, 3));
                    end
                    tick(4);
                    chk("bounce_no_ev", n_ev - n0, 0);
                    press_timed(k);
                    release_chk(k);
                end
                2: begin
                    k2 = r * 4 + (k % 4 + int'($urandom_range(1, 3))) % 4;
                    keys[k] = 1'b1;
                    keys[k2] = 1'b1;
                    tick(40);
                    chk("multi_no_ev", n_ev - n0, 0);
                    keys = '0;
                    tick(6);
                    press_timed(k);
                    k2 = (k + int'($urandom_range(1, 15))) % 16;
                    keys[k2] = 1'b1;
                    tick(30);
                    chk("rollover_no_ev", n_ev - n0, 1);
                    chk("rollover_held", int'(key_held), 1);
                    tgt = k2;
                    keys[k] = 1'b0;
                    n0 = n_ev;
                    wait_ev(80, n0);
                    chk("second_ev", n_ev - n0, 1);
                    chk("second_d0", int'(d0), kmap[k2]);
                    tick(5);
                    release_chk(k2);
                end
                3: begin
                    press_timed(k);
                    repeat (2) begin
                        keys[k] = 1'b0;
                        tick($urandom_range(1, 4));
                        keys[k] = 1'b1;
                        tick($urandom_range(3, 8));
                    end
                    chk("relbounce_no_ev", n_ev - n0, 1);
                    chk("relbounce_held", int'(key_held), 1);
                    release_chk(k);
                end
                default: begin
                    press_timed(k);
                    do_reset(1);
                    chk("midrst_d0", int'(d0), 0);
                    chk("midrst_d1", int'(d1), 0);
                    chk("midrst_rows", int'(rows), 1);
                    n0 = n_ev;
                    wait_ev(60, n0);
                    chk("reacq_ev", n_ev - n0, 1);
                    chk("reacq_d0", int'(d0), kmap[k]);
                    chk("reacq_d1", int'(d1), 0);
                    tick(5);
                    release_chk(k);
                end
            endcase
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
